// File: rtl/hazard_ctrl_seq.sv
// hazard_ctrl_seq: sequential pipeline control for stalls, exceptions, branches, jumps and multi-cycle load-use bubbles.
module hazard_ctrl_seq #(
  parameter int          REG_AW          = 5,
  parameter int          LU_STALL_CYCLES = 1,
  parameter logic [31:0] EXC_BASE        = 32'h8000_0000,
  parameter logic [31:0] INT_BASE        = 32'h8000_0180,
  parameter bit          RI_HALT         = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_jmp,
  input  logic              mem_jr,
  input  logic              mem_branch_state,
  input  logic              mem_stall,
  input  logic [31:0]       mem_excepttype,
  input  logic              idex_mem_r,
  input  logic [REG_AW-1:0] ifid_rs_addr,
  input  logic [REG_AW-1:0] ifid_real_rt_addr,
  input  logic              ifid_rs_used,
  input  logic              ifid_rt_used,
  input  logic [REG_AW-1:0] idex_real_rd_addr,
  output logic [4:0]        cu_stall,
  output logic [2:0]        cu_flush,
  output logic [2:0]        cu_pc_src,
  output logic [31:0]       cu_vector,
  output logic [3:0]        cu_cause,
  output logic              cu_exl,
  output logic              cu_halted
);
  typedef enum logic [1:0] {IDLE, LU_STALL, HALT} state_t;
  state_t      state;
  logic [3:0]  lu_cnt;
  logic [31:0] eff;
  logic        exc_take, is_eret, is_int, ri_halt, redirect, hazard, bubble;
  always_comb begin
    eff      = (cu_exl && mem_excepttype >= 32'd1 && mem_excepttype <= 32'd8) ? '0 : mem_excepttype;
    exc_take = eff != '0 && eff <= 32'hD;
    is_eret  = eff == 32'hD;
    is_int   = eff <= 32'd8;
    ri_halt  = RI_HALT && eff == 32'hA;
    redirect = mem_branch_state || mem_jr;
    hazard   = idex_mem_r && idex_real_rd_addr != '0 &&
               ((ifid_rs_used && ifid_rs_addr == idex_real_rd_addr) ||
                (ifid_rt_used && ifid_real_rt_addr == idex_real_rd_addr));
    bubble   = state == LU_STALL || hazard;
    cu_stall  = '0;
    cu_flush  = '0;
    cu_pc_src = 3'd4;
    cu_vector = '0;
    if (reset)
      cu_flush = 3'b111;
    else if (state == HALT || mem_stall)
      cu_stall = 5'b11111;
    else if (exc_take) begin
      cu_flush  = 3'b111;
      cu_pc_src = is_eret ? 3'd2 : 3'd1;
      cu_vector = is_eret ? '0 : is_int ? INT_BASE : EXC_BASE;
      cu_stall  = ri_halt ? 5'b11111 : 5'b00000;
    end else if (redirect) begin
      cu_pc_src = 3'd3;
      cu_flush  = 3'b011;
    end else if (id_jmp)
      cu_pc_src = 3'd0;
    else if (bubble) begin
      cu_stall = 5'b00011;
      cu_flush = 3'b010;
    end
  end
  // A jump outranks a bubble, so the count only advances on cycles that really emit one.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lu_cnt    <= '0;
      cu_cause  <= '0;
      cu_exl    <= 1'b0;
      cu_halted <= 1'b0;
    end else if (state != HALT && !mem_stall) begin
      if (exc_take) begin
        state     <= ri_halt ? HALT : IDLE;
        lu_cnt    <= '0;
        cu_halted <= ri_halt;
        cu_exl    <= !is_eret;
        if (!is_eret) cu_cause <= eff[3:0];
      end else if (redirect) begin
        state  <= IDLE;
        lu_cnt <= '0;
      end else if (!id_jmp && state == LU_STALL) begin
        state  <= lu_cnt == 4'd1 ? IDLE : LU_STALL;
        lu_cnt <= lu_cnt - 4'd1;
      end else if (!id_jmp && hazard && LU_STALL_CYCLES > 1) begin
        state  <= LU_STALL;
        lu_cnt <= 4'(LU_STALL_CYCLES - 1);
      end
    end
  end
endmodule

// File: tb/tb_hazard_ctrl_seq.sv
// tb_hazard_ctrl_seq: directed vector table plus randomized run against a bubble-counting reference model.
module tb_hazard_ctrl_seq;
  localparam int          N    = 3;
  localparam logic [31:0] EXCV = 32'h8000_0000;
  localparam logic [31:0] INTV = 32'h8000_0180;
  typedef struct packed {
    bit rst, jmp, jr, br, ms;
    bit [31:0] exc;
    bit mr;
    bit [4:0] rs, rt;
    bit rsu, rtu;
    bit [4:0] rd;
  } in_t;
  typedef struct packed {
    bit [4:0] st;
    bit [2:0] fl, pc;
    bit [31:0] vec;
    bit [3:0] cause;
    bit exl, hlt;
  } exp_t;
  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1, id_jmp = 1'b0, mem_jr = 1'b0, mem_branch_state = 1'b0, mem_stall = 1'b0;
  logic [31:0] mem_excepttype = '0;
  logic idex_mem_r = 1'b0, ifid_rs_used = 1'b0, ifid_rt_used = 1'b0;
  logic [4:0] ifid_rs_addr = '0, ifid_real_rt_addr = '0, idex_real_rd_addr = '0;
  logic [4:0] cu_stall;
  logic [2:0] cu_flush, cu_pc_src;
  logic [31:0] cu_vector;
  logic [3:0] cu_cause;
  logic cu_exl, cu_halted;
  int checks = 0, errors = 0;
  vec_t tv[$];
  bit m_exl, m_hlt;
  bit [3:0] m_cause;
  int m_pend;
  hazard_ctrl_seq #(.REG_AW(5), .LU_STALL_CYCLES(N), .EXC_BASE(EXCV), .INT_BASE(INTV), .RI_HALT(1'b1)) dut (
    .clk(clk), .reset(reset), .id_jmp(id_jmp), .mem_jr(mem_jr), .mem_branch_state(mem_branch_state),
    .mem_stall(mem_stall), .mem_excepttype(mem_excepttype), .idex_mem_r(idex_mem_r),
    .ifid_rs_addr(ifid_rs_addr), .ifid_real_rt_addr(ifid_real_rt_addr), .ifid_rs_used(ifid_rs_used),
    .ifid_rt_used(ifid_rt_used), .idex_real_rd_addr(idex_real_rd_addr), .cu_stall(cu_stall),
    .cu_flush(cu_flush), .cu_pc_src(cu_pc_src), .cu_vector(cu_vector), .cu_cause(cu_cause),
    .cu_exl(cu_exl), .cu_halted(cu_halted)
  );
  always #5 clk = ~clk;
  function automatic in_t ctl(bit rst, bit jmp, bit jr, bit br, bit ms);
    in_t i = '0;
    i.rst = rst; i.jmp = jmp; i.jr = jr; i.br = br; i.ms = ms;
    return i;
  endfunction
  function automatic in_t exc(bit [31:0] c);
    in_t i = '0;
    i.exc = c;
    return i;
  endfunction
  function automatic in_t lu(bit [4:0] rd, bit [4:0] rs, bit [4:0] rt, bit rsu, bit rtu);
    in_t i = '0;
    i.mr = 1'b1; i.rd = rd; i.rs = rs; i.rt = rt; i.rsu = rsu; i.rtu = rtu;
    return i;
  endfunction
  function automatic void add(in_t i, bit [4:0] st, bit [2:0] fl, bit [2:0] pc, bit [31:0] vec,
                              bit [3:0] c, bit e, bit h);
    vec_t v;
    v.i = i;
    v.e = {st, fl, pc, vec, c, e, h};
    tv.push_back(v);
  endfunction
  task automatic apply(in_t i);
    @(negedge clk);
    reset = i.rst; id_jmp = i.jmp; mem_jr = i.jr; mem_branch_state = i.br; mem_stall = i.ms;
    mem_excepttype = i.exc; idex_mem_r = i.mr; ifid_rs_addr = i.rs; ifid_real_rt_addr = i.rt;
    ifid_rs_used = i.rsu; ifid_rt_used = i.rtu; idex_real_rd_addr = i.rd;
    #1;
  endtask
  task automatic chk(string name, int n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s #%0d: got %h, expected %h", name, n, act, exp);
    end
  endtask
  task automatic chk_all(string tag, int n, exp_t e);
    chk({tag, " stall"}, n, 32'(cu_stall), 32'(e.st));
    chk({tag, " flush"}, n, 32'(cu_flush), 32'(e.fl));
    chk({tag, " pc_src"}, n, 32'(cu_pc_src), 32'(e.pc));
    chk({tag, " vector"}, n, cu_vector, e.vec);
    chk({tag, " cause"}, n, 32'(cu_cause), 32'(e.cause));
    chk({tag, " exl"}, n, 32'(cu_exl), 32'(e.exl));
    chk({tag, " halted"}, n, 32'(cu_halted), 32'(e.hlt));
  endtask
  // Reference: tracks how many bubbles of the current load-use hazard are still owed.
  function automatic exp_t model(in_t i);
    exp_t e = '0;
    bit [31:0] c = i.exc;
    bit hz = i.mr && i.rd != 0 && ((i.rsu && i.rs == i.rd) || (i.rtu && i.rt == i.rd));
    e.pc = 3'd4; e.cause = m_cause; e.exl = m_exl; e.hlt = m_hlt;
    if (m_exl && c >= 1 && c <= 8) c = 0;
    if (i.rst) begin
      e.fl = 3'b111;
      m_exl = 0; m_cause = 0; m_hlt = 0; m_pend = 0;
    end else if (m_hlt || i.ms)
      e.st = 5'b11111;
    else if (c >= 1 && c <= 13) begin
      e.fl = 3'b111;
      m_pend = 0;
      if (c == 13) begin
        e.pc = 3'd2;
        m_exl = 0;
      end else begin
        e.pc = 3'd1;
        e.vec = c <= 8 ? INTV : EXCV;
        m_cause = c[3:0];
        m_exl = 1;
        if (c == 10) begin
          e.st = 5'b11111;
          m_hlt = 1;
        end
      end
    end else if (i.br || i.jr) begin
      e.pc = 3'd3; e.fl = 3'b011; m_pend = 0;
    end else if (i.jmp)
      e.pc = 3'd0;
    else if (m_pend > 0 || hz) begin
      e.st = 5'b00011; e.fl = 3'b010;
      m_pend = m_pend > 0 ? m_pend - 1 : N - 1;
    end
    return e;
  endfunction
  initial begin
    in_t z = '0;
    in_t ri;
    exp_t re;
    add(ctl(1, 0, 0, 0, 0), 0, 3'b111, 4, 0, 0, 0, 0);
    add(z, 0, 0, 4, 0, 0, 0, 0);
    add(lu(5, 5, 0, 1, 0), 3, 3'b010, 4, 0, 0, 0, 0);
    add(z, 3, 3'b010, 4, 0, 0, 0, 0);
    add(z, 3, 3'b010, 4, 0, 0, 0, 0);
    add(z, 0, 0, 4, 0, 0, 0, 0);
    add(lu(0, 0, 0, 1, 1), 0, 0, 4, 0, 0, 0, 0);
    add(lu(5, 5, 9, 0, 0), 0, 0, 4, 0, 0, 0, 0);
    add(lu(5, 9, 5, 0, 1), 3, 3'b010, 4, 0, 0, 0, 0);
    add(ctl(0, 0, 0, 1, 0), 0, 3'b011, 3, 0, 0, 0, 0);
    add(z, 0, 0, 4, 0, 0, 0, 0);
    add(exc(9), 0, 3'b111, 1, EXCV, 0, 0, 0);
    add(exc(3), 0, 0, 4, 0, 9, 1, 0);
    add(exc(13), 0, 3'b111, 2, 0, 9, 1, 0);
    add(exc(3), 0, 3'b111, 1, INTV, 9, 0, 0);
    add(in_t'(exc(11) | ctl(0, 0, 0, 0, 1)), 5'b11111, 0, 4, 0, 3, 1, 0);
    add(exc(11), 0, 3'b111, 1, EXCV, 3, 1, 0);
    add(exc(14), 0, 0, 4, 0, 11, 1, 0);
    add(ctl(0, 1, 0, 0, 0), 0, 0, 0, 0, 11, 1, 0);
    add(in_t'(lu(7, 7, 0, 1, 0) | ctl(0, 1, 0, 0, 0)), 0, 0, 0, 0, 11, 1, 0);
    add(exc(10), 5'b11111, 3'b111, 1, EXCV, 11, 1, 0);
    for (int k = 0; k < 20; k++)
      add(in_t'(ctl(0, 0, k[0], 1, 0) | lu(5, 5, 0, 1, 0)), 5'b11111, 0, 4, 0, 10, 1, 1);
    add(ctl(1, 0, 0, 0, 0), 0, 3'b111, 4, 0, 10, 1, 1);
    add(z, 0, 0, 4, 0, 0, 0, 0);
    add(lu(5, 5, 0, 1, 0), 3, 3'b010, 4, 0, 0, 0, 0);
    add(ctl(1, 0, 0, 0, 0), 0, 3'b111, 4, 0, 0, 0, 0);
    add(z, 0, 0, 4, 0, 0, 0, 0);
    @(posedge clk);
    foreach (tv[n]) begin
      apply(tv[n].i);
      chk_all("vec", n, tv[n].e);
    end
    m_exl = 0; m_cause = 0; m_hlt = 0; m_pend = 0;
    for (int n = 0; n < 3000; n++) begin
      int r;
      ri = '0;
      ri.rst = $urandom_range(0, 63) == 0;
      ri.ms  = $urandom_range(0, 7) == 0;
      ri.br  = $urandom_range(0, 15) == 0;
      ri.jr  = $urandom_range(0, 23) == 0;
      ri.jmp = $urandom_range(0, 11) == 0;
      r = $urandom_range(0, 15);
      ri.exc = r < 11 ? 0 : r == 15 ? 32'h1000_0001 : 32'($urandom_range(1, 15));
      if (ri.exc == 10 && $urandom_range(0, 7) != 0) ri.exc = 9;
      ri.mr  = $urandom_range(0, 1);
      ri.rd  = 5'($urandom_range(0, 3));
      ri.rs  = 5'($urandom_range(0, 3));
      ri.rt  = 5'($urandom_range(0, 3));
      ri.rsu = $urandom_range(0, 1);
      ri.rtu = $urandom_range(0, 1);
      apply(ri);
      re = model(ri);
      chk_all("rnd", n, re);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
